// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a show-ahead byte FIFO, sticky framing-error and
// overrun flags. The rx pin is synchronised, deserialised LSB first, and each
// good byte is queued for the CPU-side register logic.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clear_err,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int AW           = $clog2(BUFFER_SIZE);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          drop_q, drop_d;
  logic          ferr_q, ferr_d;

  logic          rx_meta, rx_s;

  logic [7:0]    mem [BUFFER_SIZE];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;

  // Two-flop synchroniser on the asynchronous rx pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
      drop_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
      drop_q  <= drop_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling and the push/drop/error decision
  // taken on the stop-bit sample edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    drop_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            // A pop on this same edge frees the slot the byte will use next cycle.
            if (!full || rd_en) push_d = 1'b1;
            else                drop_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign do_pop   = rd_en && !empty;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(BUFFER_SIZE));
  assign data_out = mem[rd_ptr];

  // FIFO storage; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push_q) mem[wr_ptr] <= shift_q;
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_q) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_q && !do_pop)      count <= count + 1'b1;
      else if (!push_q && do_pop) count <= count - 1'b1;
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= ferr_q | (frame_error & ~clear_err);
      overrun     <= drop_q | (overrun & ~clear_err);
    end
  end

endmodule
